// File: rtl/clock_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
// Holds the default counter width, the reset half-period, the half-period
// type, and the helper that sizes the channel-select field.
package clock_div_pkg;

  localparam int CW_DEFAULT       = 16;
  localparam int DEF_HALF_DEFAULT = 1;

  typedef logic [CW_DEFAULT-1:0] half_t;

  // A single-channel build still needs a 1-bit select port.
  function automatic int sel_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: half-period counter, active and shadow half-period
// registers, the divided output, and an optional rising-edge tick.
// The tick flop exists only when CLKDIV_TICK_EN is defined; otherwise the
// tick output is tied low.
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int CW       = CW_DEFAULT,
  parameter int DEF_HALF = DEF_HALF_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          wr,
  input  logic [CW-1:0] wr_half,
  output logic          clk_out,
  output logic          tick
);

  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] RST_H = CW'(DEF_HALF);

  logic [CW-1:0] cnt;
  logic [CW-1:0] half;
  logic [CW-1:0] shadow;
  logic          stopped;
  logic          boundary;
  logic          stopping;

  // Decode the channel condition: stopped, at a wrap point, or about to stop.
  always_comb begin
    stopped  = (half == '0);
    boundary = !stopped && (cnt == half - ONE);
    stopping = (shadow == '0);
  end

  // Shadow register takes every write, even while the channel is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= RST_H;
    end else if (wr) begin
      shadow <= wr_half;
    end
  end

  // Counter, active half-period and output; half only changes at a wrap
  // or while stopped, so no half-period is ever cut short.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      half    <= RST_H;
      clk_out <= 1'b0;
    end else if (en) begin
      if (stopped) begin
        half <= shadow;
        cnt  <= '0;
      end else if (boundary) begin
        half    <= shadow;
        cnt     <= '0;
        clk_out <= stopping ? 1'b0 : ~clk_out;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

`ifdef CLKDIV_TICK_EN
  logic rise;
  logic tick_q;

  // A rise happens at a running wrap while the output is low.
  always_comb begin
    rise = en && boundary && !stopping && !clk_out;
  end

  // Register the rise so tick lines up with the cycle clk_out is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= rise;
    end
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider (top).
// Decodes cfg_sel into per-channel write strobes and fans out clk, reset
// and en to CH independent clock_div_chan instances. Select values at or
// above CH match no channel and are dropped.
// Optional feature macro: CLKDIV_TICK_EN (per-channel rising-edge tick).
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter  int CH       = 4,
  parameter  int CW       = CW_DEFAULT,
  parameter  int DEF_HALF = DEF_HALF_DEFAULT,
  localparam int SELW     = sel_width(CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            cfg_we,
  input  logic [SELW-1:0] cfg_sel,
  input  logic [CW-1:0]   cfg_half,
  output logic [CH-1:0]   clk_out,
  output logic [CH-1:0]   tick
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    logic wr;

    assign wr = cfg_we && (cfg_sel == SELW'(i));

    clock_div_chan #(
      .CW       (CW),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .wr      (wr),
      .wr_half (cfg_half),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule
